uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the team's 8-bit UART transmitter.
- Adds configurable data width, optional parity and 1 or 2 stop bits.
- Adds an internal transmit FIFO so producers can queue bytes without polling the busy flag.
- Sits between fabric logic (debug/console streams) and the board UART TX pin; frames are sent back-to-back while data is queued.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate; BAUD_TICK = CLK_FREQ/BAUD_RATE (integer truncation), must be ≥ 2.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 16, FIFO entries, power of 2, ≥ 2.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
wr_en  in  1  push wr_data into FIFO this cycle.
wr_data  in  DATA_BITS  word to transmit, LSB sent first.
full  out  1  FIFO holds FIFO_DEPTH words.
empty  out  1  FIFO holds 0 words.
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued (excludes word in flight).
overflow  out  1  one-cycle pulse, write dropped because FIFO full.
tx  out  1  serial line, idle high, registered.
tx_busy  out  1  high while a frame is on the line.

Behaviour:
- Reset (async assert, sync-safe release):
  - tx=1, tx_busy=0, overflow=0, full=0, empty=1, fifo_count=0.
  - FIFO pointers cleared; state IDLE; baud counter 0.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- FIFO, circular buffer with wrap-around pointers:
  - Write accepted when wr_en && !full, using registered pre-cycle flags.
  - wr_en while full: data dropped, FIFO unchanged, overflow=1 next cycle for exactly one cycle. This holds even if a pop occurs the same cycle.
  - Simultaneous accepted write and pop: fifo_count unchanged.
  - full/empty/fifo_count are registered and reflect the state after the edge.
- Serializer FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_busy=0. If !empty: pop head into shift register, go to START.
  - START: tx=0 for BAUD_TICK cycles.
  - DATA: DATA_BITS bits, LSB first, each BAUD_TICK cycles; bit index counts 0..DATA_BITS-1.
  - PARITY (only if PARITY≠0): one bit period.
    - Even: parity bit = XOR of data bits.
    - Odd: parity bit = XNOR of data bits.
  - STOP: tx=1 for STOP_BITS*BAUD_TICK cycles.
    - In the last cycle: if !empty, pop and go to START (no extra idle cycle between frames); else go to IDLE.
- tx_busy=1 in START, DATA, PARITY and STOP; it stays high across back-to-back frames.
- The baud counter restarts at 0 on every state or bit transition. Bit periods are exactly BAUD_TICK clk cycles.
- Latency: wr_en at edge N into an empty FIFO with the FSM in IDLE gives empty=0 after N, pop at N+1, and tx=0 from N+2.
- Frame length = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)*BAUD_TICK cycles.
- wr_data bits above DATA_BITS do not exist; the width follows the parameter.

Test Plan:
1. CLK_FREQ=1000, BAUD_RATE=100 (BAUD_TICK=10), 8N1; write 0x55 from idle → tx=0 from cycle +2 for 10 cycles; then 1,0,1,0,1,0,1,0 at 10 cycles each; stop high 10 cycles; tx_busy high 100 cycles total; then IDLE.
2. 8E1, write 0x07 → data 1,1,1,0,0,0,0,0, parity bit 1, then stop; repeat with 0x03 → parity bit 0.
3. 7O2, write 0x41 → 7 data bits 1,0,0,0,0,0,1, parity 1, two stop periods (20 cycles high); frame = 110 cycles.
4. FIFO_DEPTH=4, write 6 words in consecutive cycles while idle → the first pops immediately; 4 queued, full=1; the 6th write raises overflow for one cycle; 5 frames are sent back-to-back with no idle gap; tx_busy stays high; empty=1 at the end.
5. Assert rst mid-DATA of the second queued frame → tx=1 and tx_busy=0 asynchronously; fifo_count=0; after release, a new write transmits correctly from START.
6. Write and pop in the same cycle with 2 words queued → fifo_count stays 2; pointer wrap after 2*FIFO_DEPTH writes preserves order (compare against a reference queue).

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the queued UART transmitter: write port, FIFO status
// and the serial line itself.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          tx;
    logic                          tx_busy;

    modport master (
        output wr_en, wr_data,
        input  full, empty, fifo_count, overflow, tx, tx_busy
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, fifo_count, overflow, tx, tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO; frames go out back-to-back
// while words are queued. Configurable data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int BAUD_TICK  = CLK_FREQ / BAUD_RATE;
    localparam int STOP_TICKS = STOP_BITS * BAUD_TICK;
    localparam int CNT_W      = $clog2(STOP_TICKS);
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_TICK - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 full;
    logic                 empty;
    logic                 overflow;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx;
    logic                 tx_busy;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    always_comb begin
        push     = bus.wr_en && !full;
        bit_end  = (baud_cnt == BIT_LAST);
        stop_end = (baud_cnt == STOP_LAST);
        pop      = !empty && ((state == S_IDLE) || (state == S_STOP && stop_end));
        head     = mem[rd_ptr];
        head_par = (PARITY == 1) ? ~^head : ^head;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Flags are registered from the post-edge occupancy so producers see the
    // state that the next write will be judged against.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= bus.wr_en && full;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

    // tx and tx_busy are registered from the current state, so the line lags
    // the FSM by one cycle uniformly and every bit period stays exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_busy <= (state != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    tx <= shreg[0];
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == IDX_LAST)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    tx <= par_bit;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (stop_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shreg   <= head;
                            par_bit <= head_par;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;
    assign bus.tx         = tx;
    assign bus.tx_busy    = tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: three transmitter configurations (8N1 depth 4, 8E1, 7O2)
// on a 10-cycle bit period, checked cycle by cycle against hand-built frames.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  ia ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) ib ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4))  ic ();

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return ia.tx;
            1:       return ib.tx;
            default: return ic.tx;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return ia.tx_busy;
            1:       return ib.tx_busy;
            default: return ic.tx_busy;
        endcase
    endfunction

    task automatic drive(input int sel, input logic en, input logic [8:0] d);
        case (sel)
            0:       begin ia.wr_en = en; ia.wr_data = d[7:0]; end
            1:       begin ib.wr_en = en; ib.wr_data = d[7:0]; end
            default: begin ic.wr_en = en; ic.wr_data = d[6:0]; end
        endcase
    endtask

    task automatic push(input int sel, input logic [8:0] d);
        drive(sel, 1'b1, d);
        @(negedge clk);
        drive(sel, 1'b0, d);
    endtask

    // Each pattern character is one 10-cycle bit period; tx checked every cycle.
    task automatic expect_line(input int sel, input string tag, input string pat);
        for (int b = 0; b < pat.len(); b++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk(tag, 32'(tx_of(sel)), 32'(pat.getc(b) == "1"));
                if (c == 0)
                    chk({tag, "_busy"}, 32'(busy_of(sel)), 32'd1);
            end
        end
    endtask

    task automatic rx_byte(output logic [7:0] d);
        int n;
        n = 0;
        d = '0;
        while (ia.tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_start_edge", 32'(ia.tx), 32'd0);
        if (ia.tx !== 1'b0)
            return;
        repeat (5) @(negedge clk);
        chk("rx_start_mid", 32'(ia.tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            d[i] = ia.tx;
        end
        repeat (10) @(negedge clk);
        chk("rx_stop", 32'(ia.tx), 32'd1);
    endtask

    logic [7:0] w4 [6]  = '{8'h01, 8'h80, 8'hA5, 8'hFF, 8'h00, 8'h3C};
    logic [7:0] w6 [10] = '{8'h3A, 8'hC5, 8'h5E, 8'h01, 8'hF0,
                            8'h99, 8'h27, 8'hB4, 8'h6D, 8'h82};
    logic [7:0] rxd;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 1'b0, 9'd0);
        drive(1, 1'b0, 9'd0);
        drive(2, 1'b0, 9'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx",     32'(ia.tx),         32'd1);
        chk("rst_busy",   32'(ia.tx_busy),    32'd0);
        chk("rst_ovf",    32'(ia.overflow),   32'd0);
        chk("rst_full",   32'(ia.full),       32'd0);
        chk("rst_empty",  32'(ia.empty),      32'd1);
        chk("rst_count",  32'(ia.fifo_count), 32'd0);
        chk("rst_tx_c",   32'(ic.tx),         32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 single frame from idle, including write-to-line latency
        push(0, 9'h055);
        chk("t1_empty", 32'(ia.empty), 32'd0);
        chk("t1_count", 32'(ia.fifo_count), 32'd1);
        @(negedge clk);
        chk("t1_lat_tx",   32'(ia.tx), 32'd1);
        chk("t1_popped",   32'(ia.fifo_count), 32'd0);
        expect_line(0, "t1", "0101010101");
        @(negedge clk);
        chk("t1_end_busy", 32'(ia.tx_busy), 32'd0);
        chk("t1_end_tx",   32'(ia.tx), 32'd1);

        // 8E1: odd count of ones gives parity 1, even count gives 0
        push(1, 9'h007);
        @(negedge clk);
        expect_line(1, "t2a", "01110000011");
        @(negedge clk);
        chk("t2a_end_busy", 32'(ib.tx_busy), 32'd0);
        push(1, 9'h003);
        @(negedge clk);
        expect_line(1, "t2b", "01100000001");

        // 7O2: 110-cycle frame, busy drops right after
        push(2, 9'h041);
        @(negedge clk);
        expect_line(2, "t3", "01000001111");
        @(negedge clk);
        chk("t3_end_busy", 32'(ic.tx_busy), 32'd0);

        // Depth-4 burst of 6 writes: one overflow, 5 back-to-back frames
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    drive(0, 1'b1, {1'b0, w4[i]});
                    @(negedge clk);
                    case (i)
                        0: chk("t4_cnt0", 32'(ia.fifo_count), 32'd1);
                        1: chk("t4_cnt1", 32'(ia.fifo_count), 32'd1);
                        3: begin
                            chk("t4_cnt3",  32'(ia.fifo_count), 32'd3);
                            chk("t4_full3", 32'(ia.full), 32'd0);
                        end
                        4: begin
                            chk("t4_full4", 32'(ia.full), 32'd1);
                            chk("t4_cnt4",  32'(ia.fifo_count), 32'd4);
                            chk("t4_ovf4",  32'(ia.overflow), 32'd0);
                        end
                        5: begin
                            chk("t4_ovf5",  32'(ia.overflow), 32'd1);
                            chk("t4_cnt5",  32'(ia.fifo_count), 32'd4);
                        end
                        default: ;
                    endcase
                end
                drive(0, 1'b0, 9'd0);
                @(negedge clk);
                chk("t4_ovf_clr",  32'(ia.overflow), 32'd0);
                chk("t4_full_hold", 32'(ia.full), 32'd1);
            end
            begin
                repeat (2) @(negedge clk);
                expect_line(0, "t4f0", "0100000001");
                expect_line(0, "t4f1", "0000000011");
                expect_line(0, "t4f2", "0101001011");
                expect_line(0, "t4f3", "0111111111");
                expect_line(0, "t4f4", "0000000001");
            end
        join
        @(negedge clk);
        chk("t4_end_busy",  32'(ia.tx_busy), 32'd0);
        chk("t4_end_empty", 32'(ia.empty), 32'd1);
        chk("t4_end_count", 32'(ia.fifo_count), 32'd0);

        // Reset in the middle of the second frame's data bits
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 9'h011 * 9'(i + 1));
            @(negedge clk);
        end
        drive(0, 1'b0, 9'd0);
        repeat (135) @(negedge clk);
        chk("t5_pre_busy",  32'(ia.tx_busy), 32'd1);
        chk("t5_pre_count", 32'(ia.fifo_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx",    32'(ia.tx), 32'd1);
        chk("t5_rst_busy",  32'(ia.tx_busy), 32'd0);
        chk("t5_rst_count", 32'(ia.fifo_count), 32'd0);
        chk("t5_rst_empty", 32'(ia.empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(0, 9'h096);
        @(negedge clk);
        expect_line(0, "t5", "0011010011");
        @(negedge clk);
        chk("t5_end_busy", 32'(ia.tx_busy), 32'd0);

        // Write coinciding with a pop, then enough traffic to wrap pointers
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    drive(0, 1'b1, {1'b0, w6[i]});
                    @(negedge clk);
                end
                drive(0, 1'b0, 9'd0);
                repeat (98) @(negedge clk);
                chk("t6_pre", 32'(ia.fifo_count), 32'd2);
                drive(0, 1'b1, {1'b0, w6[3]});
                @(negedge clk);
                drive(0, 1'b0, 9'd0);
                chk("t6_wrpop", 32'(ia.fifo_count), 32'd2);
                for (int i = 4; i < 10; i++) begin
                    int n;
                    n = 0;
                    while (ia.full && n < 3000) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("t6_feed", 32'(ia.full), 32'd0);
                    drive(0, 1'b1, {1'b0, w6[i]});
                    @(negedge clk);
                    drive(0, 1'b0, 9'd0);
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    rx_byte(rxd);
                    chk("t6_rx", 32'(rxd), 32'(w6[k]));
                end
            end
        join
        repeat (10) @(negedge clk);
        chk("t6_end_busy",  32'(ia.tx_busy), 32'd0);
        chk("t6_end_empty", 32'(ia.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
